// File: rtl/pcm_to_i2s.sv
// I2S transmitter: stereo PCM pairs in over valid/ready, SCK/WS/SD out.
// Standard I2S framing with one delay bit after each WS edge; WS=0 is left.
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16,
    parameter int SCK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUMBER_OF_BITS-1:0] left_in,
    input  logic [NUMBER_OF_BITS-1:0] right_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int NB  = NUMBER_OF_BITS;
    localparam int BCW = $clog2(SLOT_BITS);
    localparam int DW  = $clog2(SCK_DIV) + 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(SCK_DIV - 1);
    localparam logic [BCW-1:0] BC_LAST  = BCW'(SLOT_BITS - 1);
    localparam logic [BCW-1:0] BC_DATA  = BCW'(NUMBER_OF_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0]  div;
    logic [BCW-1:0] bc;
    logic [BCW-1:0] bc_nxt;
    logic           ws_nxt;
    logic           started;
    logic [NB-1:0]  l_sh;
    logic [NB-1:0]  r_sh;
    logic [NB-1:0]  sh_l;
    logic [NB-1:0]  sh_r;
    logic           full;

    logic run_tick;
    logic fall_evt;
    logic bc_wrap;
    logic slot_start;
    logic data_bit;

    assign sample_ready = ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable)  state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first fall after entering RUN always opens a left slot at bc=0.
    always_comb begin
        run_tick   = (state == RUN) && enable;
        fall_evt   = run_tick && (div == DIV_LAST) && sck;
        bc_wrap    = (bc == BC_LAST);
        slot_start = fall_evt && (!started || (bc_wrap && ws));
        bc_nxt     = bc + BCW'(1);
        ws_nxt     = ws;
        if (!started) begin
            bc_nxt = '0;
            ws_nxt = 1'b0;
        end else if (bc_wrap) begin
            bc_nxt = '0;
            ws_nxt = ~ws;
        end
        data_bit = (bc_nxt != '0) && (bc_nxt <= BC_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck     <= 1'b0;
            ws      <= 1'b1;
            sd      <= 1'b0;
            div     <= '0;
            bc      <= '0;
            started <= 1'b0;
            l_sh    <= '0;
            r_sh    <= '0;
        end else if (!run_tick) begin
            sck     <= 1'b0;
            ws      <= 1'b1;
            sd      <= 1'b0;
            div     <= '0;
            bc      <= '0;
            started <= 1'b0;
            l_sh    <= '0;
            r_sh    <= '0;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                sck <= ~sck;
            end else begin
                div <= div + DW'(1);
            end
            if (fall_evt) begin
                bc      <= bc_nxt;
                ws      <= ws_nxt;
                started <= 1'b1;
                sd      <= 1'b0;
                if (slot_start) begin
                    l_sh <= full ? sh_l : '0;
                    r_sh <= full ? sh_r : '0;
                end else if (data_bit && !ws_nxt) begin
                    sd   <= l_sh[NB-1];
                    l_sh <= l_sh << 1;
                end else if (data_bit) begin
                    sd   <= r_sh[NB-1];
                    r_sh <= r_sh << 1;
                end
            end
        end
    end

    // An underrun transfer may coincide with an accept; the new pair waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            sh_l     <= '0;
            sh_r     <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= slot_start && !full;
            if (sample_valid && !full) begin
                full <= 1'b1;
                sh_l <= left_in;
                sh_r <= right_in;
            end else if (slot_start) begin
                full <= 1'b0;
            end
        end
    end

endmodule
